full_adder_pipe: RTL and testbench
==================================

Name: full_adder_pipe

Overview:
- Parameterised ripple-carry adder built from 1-bit full-adder cells: S = A + B + Cin, with carry-out and a signed-overflow flag.
- Inputs are sampled and the result registered on the clock edge, giving one cycle of latency.
- Used as the basic arithmetic primitive in datapaths.
- With WIDTH=1 it is a registered single-bit full adder and must reproduce the full 8-row truth table.

Parameters:
- WIDTH, 1, operand and sum width in bits (legal range 1..64).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  qualifies a, b, cin this cycle
- a  input  WIDTH  operand A (unsigned or two's complement)
- b  input  WIDTH  operand B
- cin  input  1  carry-in
- out_valid  output  1  s/cout/overflow hold a fresh result
- s  output  WIDTH  sum bits
- cout  output  1  carry out of MSB
- overflow  output  1  signed overflow, (carry into MSB) XOR (carry out of MSB)

Behaviour:
- Bit cell (bit i):
  - s_i = a_i ^ b_i ^ c_i
  - c_{i+1} = (a_i & b_i) | (a_i & c_i) | (b_i & c_i)
  - c_0 = cin
  - cout = c_WIDTH
- Arithmetic: {cout, s} equals the unsigned a + b + cin exactly, WIDTH+1 bits. There is no truncation other than s dropping the carry.
- Overflow:
  - overflow = c_WIDTH ^ c_{WIDTH-1}.
  - For WIDTH=1 this is cin ^ cout, the single-bit signed interpretation.
- Reset: on any rising clk edge with rst=1, s=0, cout=0, overflow=0 and out_valid=0. Reset overrides in_valid, including mid-stream.
- Latency:
  - Inputs sampled at rising edge N with in_valid=1 appear on the outputs after edge N, with out_valid=1 during cycle N+1.
  - Throughput is one add per cycle; back-to-back valid inputs give back-to-back results.
- Idle:
  - Edge with in_valid=0 (and rst=0): out_valid goes 0.
  - s, cout and overflow hold their previous values and are not cleared.
- No combinational path from inputs to outputs; all outputs come directly from flops.
- No backpressure: the block is always ready.
- Wrap-around: all-ones + all-ones + 1 gives s = all-ones and cout = 1.

Decomposition:
- Shared package (arith_pkg): the default width constant FA_DEFAULT_WIDTH = 1. No typedefs are required.
- One sub-module, full_adder_cell: a purely combinational 1-bit cell (a, b, ci -> s, co).
  - Instantiated WIDTH times in a generate loop with a carry chain.
  - The top level adds the input/output registers, the valid flop and the overflow logic.

Test Plan:
- WIDTH=1, exhaustive sweep of {a,b,cin} from 000 to 111, one per cycle with in_valid=1.
  - The next cycle shows {s,cout} = 00, 10, 10, 01, 10, 01, 01, 11.
  - out_valid=1 throughout.
- Reset mid-stream: apply a=1, b=1, cin=1, then assert rst for one edge.
  - Next cycle: s=0, cout=0, overflow=0, out_valid=0.
  - Deassert rst and resubmit: result 1/1 returns after one cycle.
- Idle hold: valid add a=1, b=0, cin=0 (s=1), then in_valid=0 for 3 cycles.
  - out_valid=0 for those 3 cycles.
  - s stays 1 and cout stays 0.
- WIDTH=8, carry wrap: a=0xFF, b=0x00, cin=1.
  - s=0x00, cout=1, overflow=0.
- WIDTH=8, signed overflow: a=0x7F, b=0x01, cin=0.
  - s=0x80, cout=0, overflow=1.
- WIDTH=8, max case and randomised check:
  - a=0xFF, b=0xFF, cin=1 gives s=0xFF, cout=1.
  - 1000 random back-to-back vectors match the {cout,s} = a+b+cin reference at exactly one-cycle latency.

Source files
------------

// File: rtl/full_adder_pipe_pkg.sv
// arith_pkg: shared arithmetic constants
package arith_pkg;
  localparam int FA_DEFAULT_WIDTH = 1;
endpackage

// File: rtl/full_adder_pipe_if.sv
// full_adder_pipe_if: operand/result bundle for the registered adder
interface full_adder_pipe_if import arith_pkg::*; #(parameter int WIDTH = FA_DEFAULT_WIDTH) ();
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             overflow;
  modport master (output in_valid, a, b, cin, input out_valid, s, cout, overflow);
  modport slave (input in_valid, a, b, cin, output out_valid, s, cout, overflow);
endinterface

// File: rtl/full_adder_cell.sv
// full_adder_cell: combinational 1-bit full adder
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

// File: rtl/full_adder_pipe.sv
// full_adder_pipe: ripple-carry adder with registered sum, carry, overflow and valid
module full_adder_pipe import arith_pkg::*; #(parameter int WIDTH = FA_DEFAULT_WIDTH) (
  input logic              clk,
  input logic              rst,
  full_adder_pipe_if.slave bus
);
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum;
  assign c[0] = bus.cin;
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder_cell u_cell (.a(bus.a[i]), .b(bus.b[i]), .ci(c[i]), .s(sum[i]), .co(c[i+1]));
  end
  // result registers hold through idle cycles; only reset clears them
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.s         <= '0;
      bus.cout      <= 1'b0;
      bus.overflow  <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.s        <= sum;
        bus.cout     <= c[WIDTH];
        bus.overflow <= c[WIDTH] ^ c[WIDTH-1];
      end
    end
  end
endmodule

// File: tb/tb_full_adder_pipe.sv
// tb_full_adder_pipe: checks 1-bit and 8-bit registered adders against constants and a reference model
module tb_full_adder_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;

  full_adder_pipe_if #(.WIDTH(1)) i1 ();
  full_adder_pipe_if #(.WIDTH(8)) i8 ();
  full_adder_pipe #(.WIDTH(1)) d1 (.clk(clk), .rst(rst), .bus(i1.slave));
  full_adder_pipe #(.WIDTH(8)) d8 (.clk(clk), .rst(rst), .bus(i8.slave));

  typedef struct {
    int         w;
    logic [7:0] a, b;
    logic       cin;
    logic [7:0] s;
    logic       cout, ov;
  } vec_t;
  vec_t tv[13];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", n, act, exp);
    end
  endtask

  task automatic drive1(input logic v, input logic a, input logic b, input logic cin);
    i1.in_valid = v; i1.a = a; i1.b = b; i1.cin = cin;
  endtask

  task automatic drive8(input logic v, input logic [7:0] a, input logic [7:0] b, input logic cin);
    i8.in_valid = v; i8.a = a; i8.b = b; i8.cin = cin;
  endtask

  initial begin
    logic [8:0] exp_sum;
    logic       exp_ov;
    logic [7:0] ra, rb;
    logic       rc, rv;
    int         sr;
    tv[0]  = '{1, 8'd0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0};
    tv[1]  = '{1, 8'd0, 8'd0, 1'b1, 8'd1, 1'b0, 1'b1};
    tv[2]  = '{1, 8'd0, 8'd1, 1'b0, 8'd1, 1'b0, 1'b0};
    tv[3]  = '{1, 8'd0, 8'd1, 1'b1, 8'd0, 1'b1, 1'b0};
    tv[4]  = '{1, 8'd1, 8'd0, 1'b0, 8'd1, 1'b0, 1'b0};
    tv[5]  = '{1, 8'd1, 8'd0, 1'b1, 8'd0, 1'b1, 1'b0};
    tv[6]  = '{1, 8'd1, 8'd1, 1'b0, 8'd0, 1'b1, 1'b1};
    tv[7]  = '{1, 8'd1, 8'd1, 1'b1, 8'd1, 1'b1, 1'b0};
    tv[8]  = '{8, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    tv[9]  = '{8, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    tv[10] = '{8, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    tv[11] = '{8, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    tv[12] = '{8, 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0};
    drive1(1'b1, 1'b1, 1'b1, 1'b1);
    drive8(1'b1, 8'hFF, 8'hFF, 1'b1);
    tick();
    tick();
    chk("rst1_valid", i1.out_valid, 0);
    chk("rst1_s", i1.s, 0);
    chk("rst1_cout", i1.cout, 0);
    chk("rst1_ov", i1.overflow, 0);
    chk("rst8_valid", i8.out_valid, 0);
    chk("rst8_s", i8.s, 0);
    chk("rst8_cout", i8.cout, 0);
    chk("rst8_ov", i8.overflow, 0);
    rst = 1'b0;
    for (int k = 0; k < 13; k++) begin
      if (tv[k].w == 1) drive1(1'b1, tv[k].a[0], tv[k].b[0], tv[k].cin);
      else drive8(1'b1, tv[k].a, tv[k].b, tv[k].cin);
      tick();
      if (tv[k].w == 1) begin
        chk($sformatf("tv%0d_valid", k), i1.out_valid, 1);
        chk($sformatf("tv%0d_s", k), i1.s, tv[k].s);
        chk($sformatf("tv%0d_cout", k), i1.cout, tv[k].cout);
        chk($sformatf("tv%0d_ov", k), i1.overflow, tv[k].ov);
      end else begin
        chk($sformatf("tv%0d_valid", k), i8.out_valid, 1);
        chk($sformatf("tv%0d_s", k), i8.s, tv[k].s);
        chk($sformatf("tv%0d_cout", k), i8.cout, tv[k].cout);
        chk($sformatf("tv%0d_ov", k), i8.overflow, tv[k].ov);
      end
    end
    drive1(1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    chk("mid_pre_s", i1.s, 1);
    chk("mid_pre_cout", i1.cout, 1);
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", i1.out_valid, 0);
    chk("mid_rst_s", i1.s, 0);
    chk("mid_rst_cout", i1.cout, 0);
    chk("mid_rst_ov", i1.overflow, 0);
    rst = 1'b0;
    tick();
    chk("mid_post_valid", i1.out_valid, 1);
    chk("mid_post_s", i1.s, 1);
    chk("mid_post_cout", i1.cout, 1);
    drive1(1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    chk("idle_pre_s", i1.s, 1);
    chk("idle_pre_cout", i1.cout, 0);
    drive1(1'b0, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("idle%0d_valid", k), i1.out_valid, 0);
      chk($sformatf("idle%0d_s", k), i1.s, 1);
      chk($sformatf("idle%0d_cout", k), i1.cout, 0);
    end
    exp_sum = {i8.cout, i8.s};
    exp_ov = i8.overflow;
    for (int k = 0; k < 1000; k++) begin
      rv = ($urandom_range(0, 7) != 0);
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      drive8(rv, ra, rb, rc);
      if (rv) begin
        exp_sum = 9'(ra) + 9'(rb) + 9'(rc);
        sr = int'($signed(ra)) + int'($signed(rb)) + int'(rc);
        exp_ov = (sr > 127) || (sr < -128);
      end
      tick();
      chk($sformatf("rnd%0d_valid", k), i8.out_valid, rv);
      chk($sformatf("rnd%0d_sum", k), {i8.cout, i8.s}, exp_sum);
      chk($sformatf("rnd%0d_ov", k), i8.overflow, exp_ov);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
